// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: power-up delay, 7-word init table, then runtime writes.
// Optional macro CFG_RETRY_EN re-issues NACKed words up to MAX_RETRY times.
module codec_cfg_sequencer #(
    parameter logic [7:0]  DEV_ADDR    = 8'h34,
    parameter logic [15:0] STARTUP_CYC = 16'd1000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i2c_start,
    output logic [23:0] i2c_word,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic        usr_valid,
    output logic        usr_ready,
    input  logic [6:0]  usr_reg,
    input  logic [8:0]  usr_data,
    output logic        usr_done,
    output logic        usr_err,
    output logic        init_done,
    output logic        cfg_fail
);

    typedef enum logic [2:0] {
        BOOT,
        ISSUE,
        WAIT,
        RUN,
        FAIL
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;

`ifdef CFG_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    logic [RW-1:0] retry;
`endif

    // {reg[6:0], data[8:0]} for each init table slot
    function automatic logic [15:0] init_entry(input logic [2:0] i);
        logic [15:0] e;
        case (i)
            3'd0:    e = {7'h0F, 9'h000};
            3'd1:    e = {7'h04, 9'h015};
            3'd2:    e = {7'h05, 9'h000};
            3'd3:    e = {7'h06, 9'h000};
            3'd4:    e = {7'h07, 9'h042};
            3'd5:    e = {7'h08, 9'h019};
            3'd6:    e = {7'h09, 9'h001};
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    // Sequencer FSM; every output is a register updated on the transition edge.
    // init_done doubles as the "current word is a user write" flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            i2c_start <= 1'b0;
            i2c_word  <= 24'h0;
            usr_ready <= 1'b0;
            usr_done  <= 1'b0;
            usr_err   <= 1'b0;
            init_done <= 1'b0;
            cfg_fail  <= 1'b0;
`ifdef CFG_RETRY_EN
            retry     <= '0;
`endif
        end else begin
            i2c_start <= 1'b0;
            usr_done  <= 1'b0;
            usr_err   <= 1'b0;
            unique case (state)
                BOOT: begin
                    if (cnt == STARTUP_CYC) begin
                        state     <= ISSUE;
                        i2c_start <= 1'b1;
                        i2c_word  <= {DEV_ADDR, init_entry(3'd0)};
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
`ifdef CFG_RETRY_EN
                            retry <= '0;
`endif
                            if (init_done) begin
                                usr_done  <= 1'b1;
                                usr_ready <= 1'b1;
                                state     <= RUN;
                            end else if (idx == 3'd6) begin
                                init_done <= 1'b1;
                                usr_ready <= 1'b1;
                                state     <= RUN;
                            end else begin
                                idx       <= idx + 3'd1;
                                i2c_start <= 1'b1;
                                i2c_word  <= {DEV_ADDR, init_entry(idx + 3'd1)};
                                state     <= ISSUE;
                            end
                        end else
`ifdef CFG_RETRY_EN
                        if (retry < RMAX) begin
                            retry     <= retry + 1'b1;
                            i2c_start <= 1'b1;
                            state     <= ISSUE;
                        end else
`endif
                        begin
`ifdef CFG_RETRY_EN
                            retry <= '0;
`endif
                            if (init_done) begin
                                usr_err   <= 1'b1;
                                usr_ready <= 1'b1;
                                state     <= RUN;
                            end else begin
                                cfg_fail <= 1'b1;
                                state    <= FAIL;
                            end
                        end
                    end
                end
                RUN: begin
                    if (usr_valid) begin
                        usr_ready <= 1'b0;
                        i2c_start <= 1'b1;
                        i2c_word  <= {DEV_ADDR, usr_reg, usr_data};
                        state     <= ISSUE;
`ifdef CFG_RETRY_EN
                        retry     <= '0;
`endif
                    end
                end
                FAIL: begin
                    usr_ready <= 1'b0;
                    init_done <= 1'b0;
                    cfg_fail  <= 1'b1;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer with an I2C engine model.
// Expected words/events come from a table-and-retry model of the sequencing rules.
module tb_codec_cfg_sequencer;

    localparam logic [15:0] SC = 16'd4;
    localparam int MR = 3;
`ifdef CFG_RETRY_EN
    localparam int R = MR;
`else
    localparam int R = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2c_start;
    logic [23:0] i2c_word;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        usr_valid = 1'b0;
    logic        usr_ready;
    logic [6:0]  usr_reg = 7'h0;
    logic [8:0]  usr_data = 9'h0;
    logic        usr_done;
    logic        usr_err;
    logic        init_done;
    logic        cfg_fail;

    codec_cfg_sequencer #(
        .DEV_ADDR    (8'h34),
        .STARTUP_CYC (SC),
        .MAX_RETRY   (MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_start (i2c_start),
        .i2c_word  (i2c_word),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .usr_valid (usr_valid),
        .usr_ready (usr_ready),
        .usr_reg   (usr_reg),
        .usr_data  (usr_data),
        .usr_done  (usr_done),
        .usr_err   (usr_err),
        .init_done (init_done),
        .cfg_fail  (cfg_fail)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    logic [23:0] exp_q[$];
    int          ev_q[$];
    bit          resp_q[$];

    int lat_fix = 0;
    int stray_cnt = 0;
    int stray_seen = 0;
    int n_starts = 0;
    int cyc = 0;
    bit first_pend = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_init = 1'b0;
    logic prev_fail = 1'b0;

    int tbl_reg[7]  = '{'h0F, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09};
    int tbl_data[7] = '{'h000, 'h015, 'h000, 'h000, 'h042, 'h019, 'h001};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ev(input string nm, input int code);
        if (ev_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got event %0d expected none", nm, code);
        end else begin
            chk(nm, code, ev_q.pop_front());
        end
    endtask

    // I2C engine model: answers each start after a latency with the queued ACK/NACK
    int  eng_cnt = 0;
    bit  eng_busy = 1'b0;
    bit  eng_nack = 1'b0;
    always @(negedge clk) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (rst) begin
            eng_busy = 1'b0;
            stray_seen = stray_cnt;
        end else if (eng_busy) begin
            if (eng_cnt <= 1) begin
                i2c_done = 1'b1;
                i2c_nack = eng_nack;
                eng_busy = 1'b0;
            end else begin
                eng_cnt--;
            end
        end else if (i2c_start) begin
            eng_busy = 1'b1;
            eng_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 12));
            eng_nack = (resp_q.size() != 0) ? resp_q.pop_front() : 1'b0;
        end else if (stray_cnt != stray_seen) begin
            i2c_done = 1'b1;
            i2c_nack = 1'($urandom_range(0, 1));
            stray_seen++;
        end
    end

    // Monitor: pops the scoreboard on every DUT output event
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cyc = 0;
            n_starts = 0;
            first_pend = 1'b1;
            prev_ready = 1'b0;
            prev_init = 1'b0;
            prev_fail = 1'b0;
        end else begin
            cyc++;
            if (i2c_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL start_word: got %h expected none", i2c_word);
                end else begin
                    chk("start_word", {8'h0, i2c_word}, {8'h0, exp_q.pop_front()});
                end
                if (first_pend)
                    chk("first_start_cycle", cyc, 32'(SC) + 1);
                else
                    chk("start_latency", {31'b0, i2c_done || (usr_valid && prev_ready)}, 1);
                first_pend = 1'b0;
            end
            if (init_done && !prev_init) begin
                ev("init_done", 1);
                chk("init_done_latency", {29'b0, i2c_done, i2c_nack, usr_ready}, 3'b101);
            end
            if (usr_done) begin
                ev("usr_done", 2);
                chk("usr_done_latency", {29'b0, i2c_done, i2c_nack, usr_ready}, 3'b101);
            end
            if (usr_err) begin
                ev("usr_err", 3);
                chk("usr_err_latency", {29'b0, i2c_done, i2c_nack, usr_ready}, 3'b111);
            end
            if (cfg_fail && !prev_fail) begin
                ev("cfg_fail", 4);
                chk("fail_outputs", {28'b0, i2c_done, i2c_nack, usr_ready, init_done}, 4'b1100);
            end
            if (prev_ready && !usr_ready)
                chk("ready_drop_on_handshake", {31'b0, usr_valid}, 1);
            prev_ready = usr_ready;
            prev_init = init_done;
            prev_fail = cfg_fail;
        end
    end

    // Model: one word NACKed n times is issued min(n,R)+1 times; n>R gives up
    task automatic push_word(input logic [23:0] w, input int n, output bit bad);
        for (int k = 0; k <= R && k <= n; k++) begin
            exp_q.push_back(w);
            resp_q.push_back(k < n);
        end
        bad = (n > R);
    endtask

    task automatic model_init(input int nk[7], output bit failed);
        bit bad;
        failed = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_word({8'h34, 7'(tbl_reg[i]), 9'(tbl_data[i])}, nk[i], bad);
            if (bad) begin
                ev_q.push_back(4);
                failed = 1'b1;
                return;
            end
        end
        ev_q.push_back(1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        ev_q.delete();
        resp_q.delete();
        repeat (3) @(negedge clk);
        chk("reset_values",
            {2'b0, i2c_start, i2c_word, usr_ready, usr_done, usr_err, init_done, cfg_fail}, 0);
        rst = 1'b0;
    endtask

    task automatic wait_settle();
        int t = 0;
        while (!(init_done || cfg_fail) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("settle_in_time", {31'b0, t < 3000}, 1);
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!usr_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, {31'b0, t < 3000}, 1);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        chk("words_left", exp_q.size(), 0);
        chk("events_left", ev_q.size(), 0);
    endtask

    task automatic user_write(input logic [6:0] r, input logic [8:0] d, input int n);
        bit bad;
        push_word({8'h34, r, d}, n, bad);
        ev_q.push_back(bad ? 3 : 2);
        @(negedge clk);
        usr_valid = 1'b1;
        usr_reg = r;
        usr_data = d;
        wait_ready("accept_in_time");
        @(negedge clk);
        usr_valid = 1'b0;
        usr_reg = 7'($urandom);
        usr_data = 9'($urandom);
        wait_ready("ready_returns");
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic check_dead();
        logic seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | usr_ready | init_done | i2c_start;
        end
        chk("fail_stays_dead", {30'b0, seen, cfg_fail}, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  nk[7];
        bit  failed;
        int  t;

        // Clean init with fixed latency, then the known runtime write
        lat_fix = 10;
        nk = '{0, 0, 0, 0, 0, 0, 0};
        reset_dut();
        model_init(nk, failed);
        wait_settle();
        chk("clean_init_done", {30'b0, init_done, cfg_fail}, 2'b10);
        user_write(7'h02, 9'h079, 0);
        drain();

        // Randomized runtime writes with random NACK counts
        lat_fix = 0;
        for (int i = 0; i < 20; i++)
            user_write(7'($urandom), 9'($urandom), int'($urandom_range(0, R + 1)));
        user_write(7'h07, 9'h00A, 1);
        drain();

        // Table word 3 NACKed twice, then four times
        nk = '{0, 0, 0, 2, 0, 0, 0};
        reset_dut();
        model_init(nk, failed);
        wait_settle();
        chk("nack2_outcome", {30'b0, init_done, cfg_fail}, failed ? 2'b01 : 2'b10);
        drain();
        nk = '{0, 0, 0, 4, 0, 0, 0};
        reset_dut();
        model_init(nk, failed);
        wait_settle();
        chk("nack4_outcome", {30'b0, init_done, cfg_fail}, failed ? 2'b01 : 2'b10);
        if (failed) check_dead();
        drain();

        // usr_valid held from reset; not accepted before init completes
        usr_reg = 7'h05;
        usr_data = 9'h006;
        usr_valid = 1'b1;
        reset_dut();
        nk = '{0, 0, 0, 0, 0, 0, 0};
        model_init(nk, failed);
        push_word({8'h34, 7'h05, 9'h006}, 0, failed);
        ev_q.push_back(2);
        wait_settle();
        wait_ready("held_accept");
        chk("held_accept_after_init", {31'b0, init_done}, 1);
        @(negedge clk);
        usr_valid = 1'b0;
        wait_ready("held_ready_returns");

        // Stray done pulses in RUN change nothing
        for (int i = 0; i < 3; i++) begin
            stray_cnt++;
            repeat (4) @(negedge clk);
            chk("stray_no_effect",
                {28'b0, usr_ready, init_done, cfg_fail, i2c_start}, 4'b1100);
        end
        drain();

        // Reset while waiting on table word 5, then a clean restart
        reset_dut();
        nk = '{0, 0, 0, 0, 0, 0, 0};
        model_init(nk, failed);
        t = 0;
        while (n_starts < 6 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_word5", {31'b0, t < 3000}, 1);
        repeat (2) @(negedge clk);
        reset_dut();
        model_init(nk, failed);
        wait_settle();
        chk("restart_init_done", {30'b0, init_done, cfg_fail}, 2'b10);
        drain();

        // Random init NACK patterns followed by a few writes
        for (int r = 0; r < 4; r++) begin
            reset_dut();
            for (int i = 0; i < 7; i++)
                nk[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, R + 1)) : 0;
            model_init(nk, failed);
            wait_settle();
            chk("rand_init_outcome", {30'b0, init_done, cfg_fail}, failed ? 2'b01 : 2'b10);
            if (failed) begin
                check_dead();
            end else begin
                for (int i = 0; i < 3; i++)
                    user_write(7'($urandom), 9'($urandom), int'($urandom_range(0, R + 1)));
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Sequences WM8731 codec register writes over the byte-level I2C write engine. After reset it waits a power-up delay, then issues the fixed 7-entry init table. It then accepts single runtime register writes from user logic, such as volume or format changes, on a valid/ready port. It sits between the top-level control and the I2C engine, and it is the sole owner of that engine.

## Interface
- `DEV_ADDR`, default 8'h34: I2C address byte with the write bit included; forms `i2c_word[23:16]`.
- `STARTUP_CYC`, default 16'd1000: cycles to wait in BOOT before the first write; 0 is legal.
- `MAX_RETRY`, default 3: re-issues allowed per word after NACK; only used with `CFG_RETRY_EN`.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i2c_start` out 1: one-cycle pulse that launches `i2c_word`.
- `i2c_word` out 24: {`DEV_ADDR`, reg[6:0], data[8:0]}; stable from `i2c_start` until `i2c_done`.
- `i2c_done` in 1: one-cycle pulse when the engine finishes a word.
- `i2c_nack` in 1: sampled only together with `i2c_done`; 1 means NACK.
- `usr_valid` in 1: runtime write request.
- `usr_ready` out 1: high only in RUN.
- `usr_reg` in 7: register index for the runtime write.
- `usr_data` in 9: register data for the runtime write.
- `usr_done` out 1: one-cycle pulse when a runtime write is ACKed.
- `usr_err` out 1: one-cycle pulse when a runtime write is finally NACKed.
- `init_done` out 1: level; goes high once all table words are ACKed.
- `cfg_fail` out 1: level; the init sequence failed; sticky until `rst`.

## Operation
- Init table, as {reg, data}, issued in index order 0..6:
  - (0x0F, 0x000)
  - (0x04, 0x015)
  - (0x05, 0x000)
  - (0x06, 0x000)
  - (0x07, 0x042)
  - (0x08, 0x019)
  - (0x09, 0x001)
- State BOOT: the 16-bit counter counts up to `STARTUP_CYC`, then goes to ISSUE. `idx`=0.
- State ISSUE (exactly 1 cycle): `i2c_start`=1; `i2c_word` is loaded from table[idx], or from the latched user word. Next state is WAIT.
- State WAIT, holding until `i2c_done`:
  - ACK during init: `idx`++ and the retry count clears. If `idx` was 6, go to RUN; otherwise go to ISSUE.
  - ACK on a user write: pulse `usr_done` and go to RUN.
  - NACK: see Configuration.
- State RUN: `usr_ready`=1. On `usr_valid`&&`usr_ready`, latch {`DEV_ADDR`, `usr_reg`, `usr_data`} and go to ISSUE.
- State FAIL: terminal. `cfg_fail`=1, `usr_ready`=0, `init_done`=0. Only `rst` leaves this state.
- `i2c_done` outside WAIT is ignored, and `i2c_nack` without `i2c_done` is ignored.
- `usr_valid` during BOOT, init, or a user write is not accepted. The requester holds the request; there is no queueing.
- `rst` asserted in any state, including mid-word in WAIT, returns the block to BOOT on the next edge and restarts from `idx`=0. The engine is reset by the same `rst`.

## Timing
- Reset values: `i2c_start`=0, `i2c_word`=24'h0, `usr_ready`=0, `usr_done`=0, `usr_err`=0, `init_done`=0, `cfg_fail`=0. State is BOOT, `idx`=0, retry count 0.
- All outputs are registered.
- First `i2c_start` occurs at cycle `STARTUP_CYC`+1 after `rst` deasserts.
- `i2c_done` ACKed at cycle M leads to the next `i2c_start` at M+1 during init.
- The last init ACK at cycle M raises `init_done` and `usr_ready` at M+1.
- User handshake at cycle N gives `i2c_start` at N+1.
- A user ACK at cycle M gives `usr_done` at M+1, with `usr_ready` also returning at M+1.
- A handshake is one cycle: `usr_ready` drops the cycle after acceptance.

## Configuration
- `CFG_RETRY_EN` defined:
  - On NACK in WAIT with retry count < `MAX_RETRY`: count++ and go to ISSUE, re-sending the same word. The `i2c_start` comes at done+1.
  - Once the count reaches `MAX_RETRY`: during init go to FAIL; on a user write pulse `usr_err` and go to RUN.
  - The count clears on every ACK and on every new word.
- `CFG_RETRY_EN` undefined:
  - The first NACK is final, with the same init and user outcomes as an exhausted retry count.
  - The retry counter logic and the `MAX_RETRY` use are not compiled in.

## Test plan
- Clean init with `STARTUP_CYC`=4 and the engine model ACKing 10 cycles after each start:
  - first `i2c_start` at cycle 5 with `i2c_word`=24'h341E00;
  - 7 starts in table order, second word 24'h340815;
  - `init_done`=1 one cycle after the 7th done.
- Runtime write after init: `usr_reg`=0x02, `usr_data`=0x079 → `i2c_word`=24'h340479 one cycle after the handshake; `usr_done` pulses; `usr_ready` is back high.
- NACK on table word 3 with `CFG_RETRY_EN` and `MAX_RETRY`=3:
  - NACK twice, then ACK → word 24'h340C00 is issued 3 times, init completes, `cfg_fail`=0;
  - NACK 4 times → `cfg_fail`=1 and `usr_ready` stays 0.
- Without `CFG_RETRY_EN`: a single NACK on a user write → `usr_err` pulses once, no re-send, back in RUN.
- `usr_valid` held high from reset → not accepted until the cycle after `init_done`. Stray `i2c_done` pulses in RUN produce no state change.
- `rst` pulsed while waiting on word 5 → all outputs return to reset values, and after `STARTUP_CYC` the sequence restarts at 24'h341E00.
